// File: rtl/scene_compositor.sv
// rtl/scene_compositor.sv - game scene sequencer and pixel layer compositor
module scene_compositor #(
  parameter int               RGB_W      = 16,
  parameter int               N_LAYERS   = 4,
  parameter int               SCORE_W    = 8,
  parameter int               H_ACTIVE   = 640,
  parameter int               V_ACTIVE   = 480,
  parameter int               START_HOLD = 30,
  parameter int               OVER_HOLD  = 120,
  parameter logic [RGB_W-1:0] BG_COLOR   = 16'h0000
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [9:0]                x_in,
  input  logic [9:0]                y_in,
  input  logic                      key_any,
  input  logic                      game_over,
  input  logic                      game_won,
  input  logic [SCORE_W-1:0]        score_in,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_valid,
  output logic [RGB_W-1:0]          pix_rgb,
  output logic [1:0]                scene,
  output logic                      game_run,
  output logic                      game_reset,
  output logic [SCORE_W-1:0]        score_hold,
  output logic [SCORE_W-1:0]        hi_score
);

  localparam int HOLD_MAX = (START_HOLD > OVER_HOLD) ? START_HOLD : OVER_HOLD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [9:0]        X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]        X_END     = 10'(H_ACTIVE);
  localparam logic [9:0]        Y_END     = 10'(V_ACTIVE);
  localparam logic [HOLD_W-1:0] START_LIM = HOLD_W'(START_HOLD);
  localparam logic [HOLD_W-1:0] OVER_LIM  = HOLD_W'(OVER_HOLD);

  typedef enum logic [1:0] {
    SC_START = 2'd0,
    SC_PLAY  = 2'd1,
    SC_OVER  = 2'd2,
    SC_WON   = 2'd3
  } scene_t;

  scene_t             state;
  scene_t             pend_scene;
  logic               pend_valid;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               k_meta, k_sync, k_prev;

  logic               ftick;
  logic               krise;
  logic               hold_done;
  logic [HOLD_W-1:0]  hold_lim;
  logic               ev_valid;
  scene_t             ev_scene;
  logic               active;
  logic [RGB_W-1:0]   scene_rgb;
  logic               scene_valid;
  logic [RGB_W-1:0]   comp_rgb;

  assign scene     = state;
  assign ftick     = (x_in == X_LAST) && (y_in == Y_LAST);
  assign krise     = k_sync & ~k_prev;
  assign hold_lim  = (state == SC_START) ? START_LIM : OVER_LIM;
  assign hold_done = (hold_cnt >= hold_lim);
  assign active    = (x_in < X_END) && (y_in < Y_END);

  // Bring the asynchronous key level into the pixel clock domain and keep one delayed copy for edge detection
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      k_meta <= 1'b0;
      k_sync <= 1'b0;
      k_prev <= 1'b0;
    end else begin
      k_meta <= key_any;
      k_sync <= k_meta;
      k_prev <= k_sync;
    end
  end

  // Decide which scene the current cycle asks to move to, if any; won beats over when both are raised
  always_comb begin
    ev_valid = 1'b0;
    ev_scene = SC_START;
    case (state)
      SC_START: begin
        if (krise && hold_done) begin
          ev_valid = 1'b1;
          ev_scene = SC_PLAY;
        end
      end
      SC_PLAY: begin
        if (game_won) begin
          ev_valid = 1'b1;
          ev_scene = SC_WON;
        end else if (game_over) begin
          ev_valid = 1'b1;
          ev_scene = SC_OVER;
        end
      end
      default: begin
        if (krise && hold_done) begin
          ev_valid = 1'b1;
          ev_scene = SC_START;
        end
      end
    endcase
  end

  // Scene sequencer: park the first event, commit it at end of frame, and latch scores on game end
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state      <= SC_START;
      pend_scene <= SC_START;
      pend_valid <= 1'b0;
      hold_cnt   <= '0;
      game_run   <= 1'b0;
      game_reset <= 1'b0;
      score_hold <= '0;
      hi_score   <= '0;
    end else begin
      game_reset <= 1'b0;
      game_run   <= (state == SC_PLAY);
      if (ftick && pend_valid) begin
        state      <= pend_scene;
        pend_valid <= 1'b0;
        hold_cnt   <= '0;
        if (pend_scene == SC_PLAY) begin
          game_reset <= 1'b1;
        end
        if ((pend_scene == SC_OVER) || (pend_scene == SC_WON)) begin
          score_hold <= score_in;
          if (score_in > hi_score) begin
            hi_score <= score_in;
          end
        end
      end else begin
        if (ftick && !hold_done) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        if (!pend_valid && ev_valid) begin
          pend_valid <= 1'b1;
          pend_scene <= ev_scene;
        end
      end
    end
  end

  // Pick the pixel: lowest-index opaque overlay, then the current scene's page layer, then background
  always_comb begin
    scene_rgb   = layer_rgb[2*RGB_W +: RGB_W];
    scene_valid = layer_valid[2];
    case (state)
      SC_START: begin
        scene_rgb   = layer_rgb[0 +: RGB_W];
        scene_valid = layer_valid[0];
      end
      SC_PLAY: begin
        scene_rgb   = layer_rgb[RGB_W +: RGB_W];
        scene_valid = layer_valid[1];
      end
      default: begin
        scene_rgb   = layer_rgb[2*RGB_W +: RGB_W];
        scene_valid = layer_valid[2];
      end
    endcase

    comp_rgb = scene_valid ? scene_rgb : BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 3; i--) begin
      if (layer_valid[i]) begin
        comp_rgb = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
    if (!active) begin
      comp_rgb = '0;
    end
  end

  // Register the composited pixel so it lines up one cycle after its scan coordinate
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pix_rgb <= '0;
    end else begin
      pix_rgb <= comp_rgb;
    end
  end

endmodule
